// File: rtl/mode_switch_debouncer.sv
// Switch conditioner: 2-flop synchronizer, counter-qualified debounce FSM,
// press/release strobes and a level-follow or toggle mode_switch output.
module mode_switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter bit          TOGGLE_MODE     = 1'b0,
    parameter bit          MODE_RESET      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic mode_switch
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_STABLE_LO,
        S_WAIT_HI,
        S_STABLE_HI,
        S_WAIT_LO
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Pulses default low every cycle; only the commit branch raises one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            mode_q    <= MODE_RESET;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                S_STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= S_WAIT_HI;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_STABLE_HI: begin
                    if (!sync2_q) begin
                        state_q <= S_WAIT_LO;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_HI: begin
                    if (!sync2_q) begin
                        state_q <= S_STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_STABLE_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        mode_q  <= TOGGLE_MODE ? ~mode_q : 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (sync2_q) begin
                        state_q <= S_STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= S_STABLE_LO;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        mode_q    <= TOGGLE_MODE ? mode_q : 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sw_level      = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign mode_switch   = mode_q;

endmodule

// File: tb/tb_mode_switch_debouncer.sv
// Directed bench: level-follow (A) and toggle (B) instances, D=4, MODE_RESET=1,
// sharing clock, reset and raw switch input.
module tb_mode_switch_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_raw;
    logic lvl_a, prs_a, rel_a, mode_a;
    logic lvl_b, prs_b, rel_b, mode_b;

    int n_checks = 0;
    int n_fail   = 0;
    int press_cnt_a = 0, rel_cnt_a = 0, press_cnt_b = 0, rel_cnt_b = 0;
    int both_pulse = 0;

    always #5 clk = ~clk;

    mode_switch_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .TOGGLE_MODE    (1'b0),
        .MODE_RESET     (1'b1)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_raw       (sw_raw),
        .sw_level     (lvl_a),
        .press_pulse  (prs_a),
        .release_pulse(rel_a),
        .mode_switch  (mode_a)
    );

    mode_switch_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .TOGGLE_MODE    (1'b1),
        .MODE_RESET     (1'b1)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_raw       (sw_raw),
        .sw_level     (lvl_b),
        .press_pulse  (prs_b),
        .release_pulse(rel_b),
        .mode_switch  (mode_b)
    );

    always @(negedge clk) begin
        if (prs_a) press_cnt_a++;
        if (rel_a) rel_cnt_a++;
        if (prs_b) press_cnt_b++;
        if (rel_b) rel_cnt_b++;
        if ((prs_a && rel_a) || (prs_b && rel_b)) both_pulse++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] bounce;
        bounce = 8'b0111_0111;
        rst_n  = 1'b0;
        sw_raw = 1'b0;

        // Reset asserted while the raw input chatters.
        for (int i = 0; i < 6; i++) begin
            sw_raw = ~sw_raw;
            tick();
        end
        check_eq("rst_level_a", int'(lvl_a), 0);
        check_eq("rst_mode_a", int'(mode_a), 1);
        check_eq("rst_mode_b", int'(mode_b), 1);
        check_eq("rst_press_a", int'(prs_a), 0);
        check_eq("rst_release_a", int'(rel_a), 0);

        sw_raw = 1'b0;
        rst_n  = 1'b1;
        hold(20);
        check_eq("idle_level_a", int'(lvl_a), 0);
        check_eq("idle_mode_a", int'(mode_a), 1);
        check_eq("idle_pulses", press_cnt_a + rel_cnt_a + press_cnt_b + rel_cnt_b, 0);

        // Clean press: commit on edge 5 counting from the first edge after the change.
        sw_raw = 1'b1;
        hold(5);
        check_eq("press_early_level", int'(lvl_a), 0);
        check_eq("press_early_pulse", int'(prs_a), 0);
        tick();
        check_eq("press_level_a", int'(lvl_a), 1);
        check_eq("press_pulse_a", int'(prs_a), 1);
        check_eq("press_pulse_b", int'(prs_b), 1);
        check_eq("press_mode_a", int'(mode_a), 1);
        check_eq("press1_mode_b", int'(mode_b), 0);
        tick();
        check_eq("press_pulse_drop", int'(prs_a), 0);
        hold(20);
        check_eq("press_held_once", press_cnt_a, 1);

        // Clean release.
        sw_raw = 1'b0;
        hold(5);
        check_eq("rel_early_level", int'(lvl_a), 1);
        tick();
        check_eq("rel_level_a", int'(lvl_a), 0);
        check_eq("rel_pulse_a", int'(rel_a), 1);
        check_eq("rel_mode_a", int'(mode_a), 0);
        check_eq("rel1_mode_b", int'(mode_b), 0);
        tick();
        check_eq("rel_pulse_drop", int'(rel_a), 0);

        // Bounce: runs of three agreeing samples never reach the commit count.
        for (int i = 7; i >= 0; i--) begin
            sw_raw = bounce[i];
            tick();
        end
        sw_raw = 1'b0;
        hold(12);
        check_eq("bounce_level", int'(lvl_a), 0);
        check_eq("bounce_press_cnt", press_cnt_a, 1);
        check_eq("bounce_rel_cnt", rel_cnt_a, 1);
        check_eq("bounce_mode_b", int'(mode_b), 0);

        sw_raw = 1'b1;
        hold(10);
        check_eq("press2_cnt", press_cnt_a, 2);
        check_eq("press2_level", int'(lvl_a), 1);
        check_eq("press2_mode_b", int'(mode_b), 1);
        sw_raw = 1'b0;
        hold(10);
        check_eq("rel2_mode_a", int'(mode_a), 0);
        check_eq("rel2_mode_b", int'(mode_b), 1);

        sw_raw = 1'b1;
        hold(10);
        check_eq("press3_mode_b", int'(mode_b), 0);
        sw_raw = 1'b0;
        hold(10);
        check_eq("rel3_mode_b", int'(mode_b), 0);
        check_eq("toggle_press_cnt", press_cnt_b, 3);
        check_eq("toggle_rel_cnt", rel_cnt_b, 3);
        check_eq("no_dual_pulse", both_pulse, 0);

        // Async reset mid-debounce, asserted between edges.
        sw_raw = 1'b1;
        hold(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_mode_a", int'(mode_a), 1);
        check_eq("async_rst_mode_b", int'(mode_b), 1);
        check_eq("async_rst_level", int'(lvl_a), 0);
        tick();
        tick();
        rst_n = 1'b1;
        hold(5);
        check_eq("post_rst_early", int'(prs_a), 0);
        check_eq("post_rst_early_lvl", int'(lvl_a), 0);
        tick();
        check_eq("post_rst_press", int'(prs_a), 1);
        check_eq("post_rst_level", int'(lvl_a), 1);
        check_eq("post_rst_mode_b", int'(mode_b), 0);
        tick();
        check_eq("post_rst_total_press", press_cnt_a, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_switch_debouncer.md
Name: mode_switch_debouncer

Overview:
- Input conditioner that sits directly upstream of the traffic_light controller and drives its mode_switch input.
- Takes a raw mechanical switch or push-button signal and passes it through a 2-flop synchronizer.
- Debounces the synchronized signal with a counter-qualified FSM.
- Produces a clean registered mode_switch level plus single-cycle press/release strobes.
- Runs on the same 16 MHz system clock as the controller.

Parameters:
- DEBOUNCE_CYCLES, 160000: consecutive agreeing samples required to accept a new level (10 ms at 16 MHz). Must be >= 2.
- TOGGLE_MODE, 0: 0 = mode_switch follows the debounced level; 1 = mode_switch toggles on each debounced press.
- MODE_RESET, 1: reset value of mode_switch (1 = normal cycling).

Ports:
- clk  input  1  system clock, 16 MHz, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- sw_raw  input  1  raw asynchronous switch/button input, active high
- sw_level  output  1  debounced, registered switch level
- press_pulse  output  1  one-cycle strobe on debounced 0->1
- release_pulse  output  1  one-cycle strobe on debounced 1->0
- mode_switch  output  1  to traffic_light.mode_switch

Behaviour:
- Reset:
  - Asynchronous active-low reset; rst_n low forces all state immediately, independent of clk.
  - Reset values: sync flops = 0, counter = 0, FSM = S_STABLE_LO, sw_level = 0, press_pulse = 0, release_pulse = 0, mode_switch = MODE_RESET.
  - Reset mid-debounce discards the partial count; no pulse is produced.
- Synchronizer:
  - sw_raw -> sync1 -> sync2, both flops reset to 0.
  - The FSM only ever observes sync2.
- FSM states: S_STABLE_LO, S_WAIT_HI, S_STABLE_HI, S_WAIT_LO.
- Counter:
  - Width $clog2(DEBOUNCE_CYCLES).
  - Never wraps; it is cleared whenever the FSM leaves a WAIT state.
- Transitions from a STABLE state:
  - If sync2 differs from sw_level: go to the matching WAIT state, cnt <= 1.
  - Otherwise: stay, cnt <= 0.
- Transitions from a WAIT state:
  - If sync2 returns to equal sw_level (bounce): go back to STABLE of the same level, cnt <= 0, no output change.
  - Else if cnt == DEBOUNCE_CYCLES-1: commit.
  - Else: cnt <= cnt+1.
- Commit:
  - sw_level flips.
  - The FSM moves to the STABLE state of the new level, cnt <= 0.
  - press_pulse or release_pulse is asserted for exactly that one cycle.
  - Net effect: a level is accepted after DEBOUNCE_CYCLES consecutive differing sync2 samples.
- Latency:
  - If sw_raw changes before clock edge 0 and then holds, sw_level changes on edge DEBOUNCE_CYCLES+1.
  - That is 2 synchronizer edges plus DEBOUNCE_CYCLES-1 counting edges.
  - Pulses are coincident with the sw_level change.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples: no output change. The count restarts from 1 on the next differing sample.
- mode_switch, TOGGLE_MODE = 0:
  - Registered; loads sw_level's new value on each commit edge.
  - Holds MODE_RESET until the first commit.
- mode_switch, TOGGLE_MODE = 1:
  - Inverts on each press_pulse edge.
  - Releases have no effect.
- Only one commit can occur per cycle, so press_pulse and release_pulse are never asserted together.
- All outputs are registered; there is no combinational path from sw_raw to any output.
- A press held indefinitely yields exactly one press_pulse.

Test Plan:
- Reset and hold, DEBOUNCE_CYCLES = 4, MODE_RESET = 1:
  - Stimulus: rst_n low with sw_raw toggling, then rst_n high with sw_raw = 0 for 20 cycles.
  - Required: sw_level = 0, mode_switch = 1, both pulses never asserted.
- Clean press, D = 4, TOGGLE_MODE = 0:
  - Stimulus: sw_raw 0 -> 1 before edge 0, then held.
  - Required: sw_level = 1 after edge 5, press_pulse high for exactly 1 cycle at edge 5, mode_switch = 1.
  - Then sw_raw -> 0: sw_level = 0 and release_pulse = 1 for 1 cycle 5 edges later; mode_switch = 0.
- Bounce rejection, D = 4:
  - Stimulus: sw_raw pattern 1,1,1,0,1,1,1,0 (one value per cycle), then held 0.
  - Required: sw_level stays 0 and no pulses occur.
  - Follow-up: sw_raw = 1 for 4+ cycles -> single press_pulse.
- Toggle mode, D = 4, TOGGLE_MODE = 1, MODE_RESET = 1:
  - Stimulus: three clean press/release pairs, each phase held 10 cycles.
  - Required: mode_switch goes 1 -> 0 -> 1 -> 0, changing only on press_pulse edges; exactly 3 press_pulse and 3 release_pulse.
- Reset mid-operation, D = 4:
  - Stimulus: sw_raw = 1 for 3 cycles, then pulse rst_n low asynchronously between clock edges.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.
  - Required: after release with sw_raw still 1, the full D+2-edge latency applies before press_pulse.
- Integration with traffic_light (GREEN_CYCLES = 30, YELLOW_CYCLES = 5, RED_RED_CYCLES = 2, FLASH_HALF_CYCLES = 5):
  - Stimulus: debouncer drives traffic_light mode_switch; TOGGLE_MODE = 1, one press.
  - Required: mode_switch drops to 0 exactly once and the controller leaves normal cycling.
  - Required: a bounce burst shorter than D causes no mode change.
